cluster_collector: RTL
======================

Name: cluster_collector

Overview:
- Sits directly downstream of the 384-pad priority encoder.
- Consumes one encoder result per clock: valid flag, pad address, cluster size and pass tag.
- Collects the results from one bunch-crossing window into MXCLUSTERS slots, indexed by pass tag.
- On each window strobe, presents the finished set as a registered cluster frame to the packer.

Parameters:
MXCLUSTERS, 8, number of cluster slots per window (must equal 2**MXPASSB)
MXPASSB, 3, pass-tag width
MXADRB, 9, pad address width
MXCNTB, 3, cluster size width
MXDROPB, 16, drop-counter width

Ports:
clock  in  1  logic clock
reset  in  1  synchronous active-high reset
bx_strobe_i  in  1  single-cycle pulse opening a new window; closes the previous one
pass_i  in  MXPASSB  encoder pass tag (slot index) accompanying vpf_i
vpf_i  in  1  encoder found a valid cluster this cycle
adr_i  in  MXADRB  cluster pad address
cnt_i  in  MXCNTB  cluster size
clusters_o  out  MXCLUSTERS*(1+MXCNTB+MXADRB)  frame; slot k = {vpf, cnt, adr}, slot 0 in LSBs
frame_valid_o  out  1  one-cycle pulse, clusters_o updated this cycle
nclusters_o  out  MXPASSB+1  number of valid slots in frame (0..MXCLUSTERS)
overflow_o  out  1  frame contained at least one duplicate-pass drop
drop_cnt_o  out  MXDROPB  saturating total of dropped clusters since reset

Behaviour:
- Working array: MXCLUSTERS slots of {vpf, cnt, adr}.
  - Empty slot = {0, 0, all-ones adr}.
  - Per-slot written flags, plus a window overflow flag.
- Accept rule: for a cycle with vpf_i=1, slot = pass_i.
  - If slot not yet written this window: store {1, cnt_i, adr_i}; set written flag.
  - If already written: discard the new cluster (first write wins), set window overflow, increment drop_cnt (saturating at all-ones).
  - vpf_i=0 cycles never modify state, regardless of pass_i.
- Window close: on clock edge where bx_strobe_i=1:
  - clusters_o <= working array.
  - nclusters_o <= popcount of written flags.
  - overflow_o <= window overflow.
  - frame_valid_o <= 1 for exactly one cycle.
  - Working array, written flags and overflow are cleared.
- Simultaneous strobe and vpf_i=1: the input belongs to the NEW window. It is written into the freshly cleared array, not the outgoing frame.
- Latency: strobe at edge N -> frame_valid_o high and outputs valid after edge N, i.e. cycle N+1. Frame outputs hold until the next strobe.
- Back-to-back strobes: each produces a frame; an empty window yields all-empty slots, nclusters_o=0.
- Reset (synchronous, overrides everything incl. simultaneous strobe/input):
  - Working array and clusters_o all-empty.
  - frame_valid_o=0, nclusters_o=0, overflow_o=0, drop_cnt_o=0.
  - Mid-window reset discards the partial window; no frame emitted.
- Inputs arriving before the first strobe after reset are collected normally and appear in the first frame.
- pass_i is only used when vpf_i=1. No internal backpressure: the frame consumer must latch it on frame_valid_o.

Test Plan:
- Reset, then strobe with no inputs -> next cycle frame_valid_o=1, nclusters_o=0, every slot {0,0,9'h1FF}, overflow_o=0.
- Window with (pass 0, adr 17, cnt 2) and (pass 5, adr 300, cnt 7), then strobe -> slot0={1,2,17}, slot5={1,7,300}, others empty, nclusters_o=2, frame_valid_o high exactly one cycle.
- Duplicate: pass 3 adr 10, then pass 3 adr 20, then strobe -> slot3 adr 10, overflow_o=1, drop_cnt_o=1; next clean window -> overflow_o=0, drop_cnt_o stays 1.
- Strobe coincident with vpf_i=1 pass 1 adr 42 -> outgoing frame excludes it; following strobe's frame has slot1={1,cnt,42}.
- Force 65537 duplicates -> drop_cnt_o saturates at 16'hFFFF.
- Reset asserted mid-window after 3 accepted clusters, then strobe -> frame has nclusters_o=0; reset with simultaneous strobe -> no frame_valid_o pulse.

Source files
------------

// File: rtl/cluster_collector.sv
// Collects one bunch-crossing window of encoder clusters into pass-indexed slots, emits a frame per strobe.
// Latency: frame outputs and frame_valid_o register on the strobe edge, visible the following cycle.
// Backpressure: none; the consumer must latch the frame while frame_valid_o is high.
module cluster_collector #(
    parameter int MXCLUSTERS = 8,
    parameter int MXPASSB    = 3,
    parameter int MXADRB     = 9,
    parameter int MXCNTB     = 3,
    parameter int MXDROPB    = 16
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       bx_strobe_i,
    input  logic [MXPASSB-1:0]                         pass_i,
    input  logic                                       vpf_i,
    input  logic [MXADRB-1:0]                          adr_i,
    input  logic [MXCNTB-1:0]                          cnt_i,
    output logic [MXCLUSTERS*(1+MXCNTB+MXADRB)-1:0]    clusters_o,
    output logic                                       frame_valid_o,
    output logic [MXPASSB:0]                           nclusters_o,
    output logic                                       overflow_o,
    output logic [MXDROPB-1:0]                         drop_cnt_o
);

    typedef struct packed {
        logic              vpf;
        logic [MXCNTB-1:0] cnt;
        logic [MXADRB-1:0] adr;
    } slot_t;

    localparam slot_t EMPTY_SLOT = '{vpf: 1'b0, cnt: '0, adr: '1};

    slot_t [MXCLUSTERS-1:0] work;
    logic  [MXCLUSTERS-1:0] written;
    logic                   win_ovf;
    logic                   accept;
    logic                   dup;

    function automatic logic [MXPASSB:0] popcount(input logic [MXCLUSTERS-1:0] v);
        logic [MXPASSB:0] n;
        n = '0;
        for (int k = 0; k < MXCLUSTERS; k++)
            n = n + {{MXPASSB{1'b0}}, v[k]};
        return n;
    endfunction

    // A strobe clears the array first, so a coincident input always lands as a fresh write.
    always_comb begin
        accept = vpf_i && (bx_strobe_i || !written[pass_i]);
        dup    = vpf_i && !bx_strobe_i && written[pass_i];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            work          <= {MXCLUSTERS{EMPTY_SLOT}};
            written       <= '0;
            win_ovf       <= 1'b0;
            clusters_o    <= {MXCLUSTERS{EMPTY_SLOT}};
            frame_valid_o <= 1'b0;
            nclusters_o   <= '0;
            overflow_o    <= 1'b0;
            drop_cnt_o    <= '0;
        end else begin
            frame_valid_o <= bx_strobe_i;
            if (bx_strobe_i) begin
                clusters_o  <= work;
                nclusters_o <= popcount(written);
                overflow_o  <= win_ovf;
                work        <= {MXCLUSTERS{EMPTY_SLOT}};
                written     <= '0;
                win_ovf     <= 1'b0;
            end
            if (accept) begin
                work[pass_i]    <= '{vpf: 1'b1, cnt: cnt_i, adr: adr_i};
                written[pass_i] <= 1'b1;
            end
            if (dup) begin
                win_ovf <= 1'b1;
                if (drop_cnt_o != {MXDROPB{1'b1}})
                    drop_cnt_o <= drop_cnt_o + {{(MXDROPB-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
